spiker_sequencer: RTL
=====================

Name: spiker_sequencer

Overview:
- Timestep controller for the spiker accelerator core. It sequences one inference of N timesteps.
- Each timestep: latch the spike vector published by the register-file reader, stream it to the core in CHUNK_W-bit beats over valid/ready, then wait for the core's step-done.
- Accumulates per-class output spike counts across timesteps. Raises done/irq for software when the run completes.

Parameters:
- DATA_WIDTH, 800: spike vector width. Must be a multiple of CHUNK_W.
- CHUNK_W, 32: beat width to the core. NCHUNK = DATA_WIDTH/CHUNK_W (25 at defaults).
- N_OUT, 10: number of output neurons/classes.
- CNT_W, 16: width of each per-class spike counter.
- STEP_W, 16: width of the timestep count.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  run request pulse (ctrl.start)
- abort_i  in  1  synchronous abort
- n_steps_i  in  STEP_W  timesteps per run
- spikes_i  in  DATA_WIDTH  spike vector from register reader
- step_start_o  out  1  one-cycle pulse to core at start of each timestep
- chunk_o  out  CHUNK_W  current beat
- chunk_valid_o  out  1  beat valid
- chunk_ready_i  in  1  core accepts beat
- step_done_i  in  1  core finished timestep
- out_valid_i  in  1  output spike vector valid
- out_spikes_i  in  N_OUT  output spikes
- counts_o  out  N_OUT*CNT_W  per-class counts; class k at [k*CNT_W +: CNT_W]
- step_o  out  STEP_W  index of current timestep
- busy_o  out  1  not IDLE
- done_o  out  1  run-completed flag
- irq_o  out  1  one-cycle completion pulse

Behaviour:
- Reset values: all outputs 0; state IDLE; shadow register, chunk index, step and counters cleared.
- All outputs registered or decoded directly from state. No combinational path from any input to any output.
- States: IDLE, LOAD, STREAM, WAIT, NEXT, DONE.
- IDLE:
  - start_i=1 and n_steps_i≠0 → LOAD. Latch n_steps_i, clear counters, step_o and done_o.
  - start_i=1 and n_steps_i=0 → DONE directly. Counters are cleared; no core activity.
- LOAD (1 cycle): shadow ← spikes_i; chunk index ← 0; step_start_o=1 in this cycle only → STREAM.
- STREAM:
  - chunk_valid_o=1; chunk_o = shadow[CHUNK_W-1:0]. LSB chunk goes first.
  - On valid&ready, shadow shifts right by CHUNK_W and chunk index increments.
  - The handshake on chunk index NCHUNK-1 → WAIT.
  - chunk_o and chunk_valid_o stay stable while ready=0.
- WAIT: step_done_i=1 → NEXT. step_done_i is ignored in every other state.
- NEXT (1 cycle):
  - If step_o == n_steps-1 → DONE.
  - Otherwise step_o+1 → LOAD.
- DONE (1 cycle): done_o ← 1; irq_o=1 for this cycle → IDLE.
- Latency at defaults with ready tied 1 and zero-latency step_done:
  - start → first step_start_o: 1 cycle.
  - Each timestep: 1 (LOAD) + 25 (STREAM) + WAIT + 1 (NEXT) cycles.
- Counters:
  - Any cycle with busy_o=1 and out_valid_i=1: counter k increments for each out_spikes_i[k]=1.
  - Each counter saturates at 2^CNT_W-1; it never wraps.
  - out_valid_i is ignored in IDLE.
- done_o holds 1 until the next accepted start or reset. counts_o holds its values after done until the next accepted start.
- start_i while busy_o=1: ignored.
- abort_i (highest priority, any non-IDLE state):
  - Next state is IDLE; chunk_valid_o drops next cycle.
  - No irq_o pulse; done_o stays 0; counters keep their partial values.
  - Abort and start in the same IDLE cycle: start wins.
- Asynchronous reset mid-run: immediate return to reset values. Any in-flight beat is dropped.

Optional Feature:
- Macro SPIKER_SEQ_ARGMAX_EN.
- When defined:
  - Adds output class_o, width $clog2(N_OUT), plus class_valid_o.
  - In DONE the block computes the argmax of the counters. Ties resolve to the lowest index.
  - class_o and class_valid_o register in the same cycle done_o rises.
  - class_valid_o clears on the next accepted start.
  - The argmax may be a combinational compare tree over the frozen counters.
- When not defined: neither port exists and no comparator logic is generated.

Test Plan:
- Defaults, n_steps=2, ready=1, step_done 3 cycles after entering WAIT, spikes_i = incrementing 32-bit words 0..24:
  - Beats 0..24 in order, twice.
  - step_start_o pulses 2.
  - done_o=1 and irq_o=1-cycle pulse at end; step_o=1.
- chunk_ready_i toggling 1-0-1:
  - chunk_o stable across stalls; exactly 25 beats accepted; no duplicates or skips.
- n_steps=3, out_valid_i with out_spikes_i=10'b0000000101 once per step:
  - counts[0]=3, counts[2]=3, all others 0.
- CNT_W=4, 20 spikes on class 1:
  - counts[1]=15 (saturates).
- abort_i mid-STREAM at beat 7:
  - IDLE next cycle, chunk_valid_o=0, no irq, done_o=0.
  - A subsequent start runs normally from beat 0.
- n_steps=0:
  - done/irq 2 cycles after start; no step_start_o.
- Start while busy: ignored.
- With SPIKER_SEQ_ARGMAX_EN, counts {3,7,7,...}:
  - class_o=1.

Source files
------------

// File: rtl/spiker_sequencer.sv
// spiker_sequencer: timestep controller for the spiker accelerator core.
// Per timestep it latches the published spike vector, streams it LSB-chunk
// first to the core over valid/ready, waits for step-done, and accumulates
// saturating per-class output spike counts across the run.
// Optional argmax classifier output is enabled by defining SPIKER_SEQ_ARGMAX_EN.
// Handshake: a beat transfers on every rising clock edge where chunk_valid_o
// and chunk_ready_i are both 1; while ready is 0 the beat and valid hold.
module spiker_sequencer #(
    parameter int DATA_WIDTH = 800,
    parameter int CHUNK_W    = 32,
    parameter int N_OUT      = 10,
    parameter int CNT_W      = 16,
    parameter int STEP_W     = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    input  logic                     abort_i,
    input  logic [STEP_W-1:0]        n_steps_i,
    input  logic [DATA_WIDTH-1:0]    spikes_i,
    output logic                     step_start_o,
    output logic [CHUNK_W-1:0]       chunk_o,
    output logic                     chunk_valid_o,
    input  logic                     chunk_ready_i,
    input  logic                     step_done_i,
    input  logic                     out_valid_i,
    input  logic [N_OUT-1:0]         out_spikes_i,
    output logic [N_OUT*CNT_W-1:0]   counts_o,
    output logic [STEP_W-1:0]        step_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     irq_o,
`ifdef SPIKER_SEQ_ARGMAX_EN
    output logic [$clog2(N_OUT)-1:0] class_o,
    output logic                     class_valid_o,
`endif
    output logic [2:0]               state_o
);

    localparam int NCHUNK = DATA_WIDTH / CHUNK_W;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_STREAM = 3'd2,
        S_WAIT   = 3'd3,
        S_NEXT   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   shadow_q;
    logic [IDX_W-1:0]        idx_q;
    logic [STEP_W-1:0]       step_q;
    logic [STEP_W-1:0]       n_steps_q;
    logic                    done_q;
    logic [CNT_W-1:0]        cnt_q [N_OUT];

    logic start_acc;
    logic abort_hit;
    logic beat_fire;
    logic last_step;

    assign start_acc = (state_q == S_IDLE) && start_i;
    assign abort_hit = (state_q != S_IDLE) && abort_i;
    assign beat_fire = (state_q == S_STREAM) && chunk_ready_i;
    assign last_step = (step_q == n_steps_q - STEP_W'(1));

    // Outputs decoded from state or taken straight from registers.
    assign step_start_o  = (state_q == S_LOAD);
    assign chunk_valid_o = (state_q == S_STREAM);
    assign chunk_o       = shadow_q[CHUNK_W-1:0];
    assign busy_o        = (state_q != S_IDLE);
    assign irq_o         = (state_q == S_DONE);
    assign done_o        = done_q;
    assign step_o        = step_q;
    assign state_o       = state_q;

    for (genvar g = 0; g < N_OUT; g++) begin : g_counts
        assign counts_o[g*CNT_W +: CNT_W] = cnt_q[g];
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic; abort overrides every non-idle transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_i) state_d = (n_steps_i == '0) ? S_DONE : S_LOAD;
            S_LOAD:   state_d = S_STREAM;
            S_STREAM: if (chunk_ready_i && (idx_q == LAST_IDX)) state_d = S_WAIT;
            S_WAIT:   if (step_done_i) state_d = S_NEXT;
            S_NEXT:   state_d = last_step ? S_DONE : S_LOAD;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (abort_hit) state_d = S_IDLE;
    end

    // Shadow vector and chunk index: load per timestep, shift per accepted beat.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shadow_q <= '0;
            idx_q    <= '0;
        end else if (state_q == S_LOAD) begin
            shadow_q <= spikes_i;
            idx_q    <= '0;
        end else if (beat_fire) begin
            shadow_q <= shadow_q >> CHUNK_W;
            idx_q    <= idx_q + IDX_W'(1);
        end
    end

    // Run bookkeeping: step count, latched length and sticky done flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            step_q    <= '0;
            n_steps_q <= '0;
            done_q    <= 1'b0;
        end else if (start_acc) begin
            step_q    <= '0;
            n_steps_q <= n_steps_i;
            done_q    <= 1'b0;
        end else if (!abort_hit) begin
            if ((state_q == S_NEXT) && !last_step) step_q <= step_q + STEP_W'(1);
            if (state_q == S_DONE) done_q <= 1'b1;
        end
    end

    // Saturating per-class spike counters, cleared by an accepted start.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < N_OUT; k++) cnt_q[k] <= '0;
        end else if (start_acc) begin
            for (int k = 0; k < N_OUT; k++) cnt_q[k] <= '0;
        end else if (busy_o && out_valid_i) begin
            for (int k = 0; k < N_OUT; k++) begin
                if (out_spikes_i[k] && (cnt_q[k] != {CNT_W{1'b1}}))
                    cnt_q[k] <= cnt_q[k] + CNT_W'(1);
            end
        end
    end

`ifdef SPIKER_SEQ_ARGMAX_EN
    localparam int CLS_W = $clog2(N_OUT);

    logic [CLS_W-1:0] argmax_idx;
    logic [CNT_W-1:0] argmax_val;
    logic [CLS_W-1:0] class_q;
    logic             class_valid_q;

    assign class_o       = class_q;
    assign class_valid_o = class_valid_q;

    // Argmax over the counters; strict compare keeps the lowest index on ties.
    always_comb begin
        argmax_idx = '0;
        argmax_val = cnt_q[0];
        for (int k = 1; k < N_OUT; k++) begin
            if (cnt_q[k] > argmax_val) begin
                argmax_val = cnt_q[k];
                argmax_idx = CLS_W'(k);
            end
        end
    end

    // Capture the winning class alongside the done flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            class_q       <= '0;
            class_valid_q <= 1'b0;
        end else if (start_acc) begin
            class_valid_q <= 1'b0;
        end else if ((state_q == S_DONE) && !abort_hit) begin
            class_q       <= argmax_idx;
            class_valid_q <= 1'b1;
        end
    end
`endif

endmodule
